// File: rtl/npu_ctrl_pkg.sv
// Shared constants for the NPU control register block: register byte
// offsets, STATUS bit positions, the AXI OKAY response and the write
// channel state type.
package npu_ctrl_pkg;

    localparam logic [4:0] ADDR_CTRL    = 5'h00;
    localparam logic [4:0] ADDR_ARG0    = 5'h04;
    localparam logic [4:0] ADDR_ARG1    = 5'h08;
    localparam logic [4:0] ADDR_SCRATCH = 5'h0C;
    localparam logic [4:0] ADDR_STATUS  = 5'h10;
    localparam logic [4:0] ADDR_CYCLES  = 5'h14;

    localparam int STATUS_BUSY_BIT = 0;
    localparam int STATUS_DONE_BIT = 1;

    localparam logic [1:0] RESP_OKAY = 2'b00;

    typedef enum logic [1:0] {
        IDLE,
        HAVE_AW,
        HAVE_W,
        RESP
    } wr_state_t;

    // Merge new_word into old_word one byte lane at a time under strb.
    function automatic logic [31:0] apply_strb(input logic [31:0] old_word,
                                               input logic [31:0] new_word,
                                               input logic [3:0]  strb);
        logic [31:0] res;
        res = old_word;
        for (int i = 0; i < 4; i++) begin
            if (strb[i]) begin
                res[8*i +: 8] = new_word[8*i +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/npu_ctrl_axil_wr_ch.sv
// AXI4-Lite write channel: accepts AW and W independently in either order,
// then issues a one-cycle write strobe to the register file together with
// the rise of BVALID. Only one write is in flight at a time.
module npu_ctrl_axil_wr_ch
    import npu_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  awaddr,
    input  logic        awvalid,
    output logic        awready,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    input  logic        wvalid,
    output logic        wready,
    output logic [1:0]  bresp,
    output logic        bvalid,
    input  logic        bready,
    output logic        wr_en,
    output logic [4:0]  wr_addr,
    output logic [31:0] wr_data,
    output logic [3:0]  wr_strb
);

    wr_state_t   state;
    logic [4:0]  addr_q;
    logic [31:0] data_q;
    logic [3:0]  strb_q;
    logic        aw_hs;
    logic        w_hs;
    logic        aw_open;
    logic        w_open;

    assign aw_hs   = awvalid && awready;
    assign w_hs    = wvalid && wready;
    assign aw_open = (state == IDLE) || (state == HAVE_W);
    assign w_open  = (state == IDLE) || (state == HAVE_AW);

    assign bresp   = RESP_OKAY;
    assign wr_addr = addr_q;
    assign wr_data = data_q;
    assign wr_strb = strb_q;

    // Ready pulses, address/data capture and the AW/W/B sequencing FSM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            awready <= 1'b0;
            wready  <= 1'b0;
            bvalid  <= 1'b0;
            wr_en   <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            strb_q  <= '0;
        end else begin
            awready <= aw_open && !bvalid && awvalid && !awready;
            wready  <= w_open && !bvalid && wvalid && !wready;
            wr_en   <= 1'b0;
            if (aw_hs) begin
                addr_q <= awaddr;
            end
            if (w_hs) begin
                data_q <= wdata;
                strb_q <= wstrb;
            end
            case (state)
                IDLE: begin
                    if (aw_hs && w_hs) begin
                        state  <= RESP;
                        bvalid <= 1'b1;
                        wr_en  <= 1'b1;
                    end else if (aw_hs) begin
                        state <= HAVE_AW;
                    end else if (w_hs) begin
                        state <= HAVE_W;
                    end
                end
                HAVE_AW: begin
                    if (w_hs) begin
                        state  <= RESP;
                        bvalid <= 1'b1;
                        wr_en  <= 1'b1;
                    end
                end
                HAVE_W: begin
                    if (aw_hs) begin
                        state  <= RESP;
                        bvalid <= 1'b1;
                        wr_en  <= 1'b1;
                    end
                end
                RESP: begin
                    if (bready) begin
                        state  <= IDLE;
                        bvalid <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/npu_ctrl_axil_regs.sv
// AXI4-Lite register block for the NPU control path: CTRL/ARG0/ARG1/SCRATCH
// storage, STATUS (busy, sticky done) and a saturating busy-cycle counter,
// plus the start pulse to the core.
module npu_ctrl_axil_regs
    import npu_ctrl_pkg::*;
#(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 5
)
(
    input  logic                            S_AXI_ACLK,
    input  logic                            S_AXI_ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic [2:0]                      S_AXI_AWPROT,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic [2:0]                      S_AXI_ARPROT,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY,
    output logic                            npu_start,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   npu_arg0,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   npu_arg1,
    input  logic                            npu_done
);

    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic [3:0]  wr_strb;
    logic [2:0]  wr_idx;

    logic [31:0] ctrl_q;
    logic [31:0] arg0_q;
    logic [31:0] arg1_q;
    logic [31:0] scratch_q;
    logic [31:0] cycles_q;
    logic        busy_q;
    logic        done_q;

    logic        start_req;
    logic        done_clr;
    logic [31:0] rd_word;
    logic        unused_inputs;

    assign unused_inputs = ^{S_AXI_AWPROT, S_AXI_ARPROT, wr_addr[1:0], S_AXI_ARADDR[1:0]};

    npu_ctrl_axil_wr_ch u_wr_ch (
        .clk     (S_AXI_ACLK),
        .rst_n   (S_AXI_ARESETN),
        .awaddr  (S_AXI_AWADDR),
        .awvalid (S_AXI_AWVALID),
        .awready (S_AXI_AWREADY),
        .wdata   (S_AXI_WDATA),
        .wstrb   (S_AXI_WSTRB),
        .wvalid  (S_AXI_WVALID),
        .wready  (S_AXI_WREADY),
        .bresp   (S_AXI_BRESP),
        .bvalid  (S_AXI_BVALID),
        .bready  (S_AXI_BREADY),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .wr_strb (wr_strb)
    );

    assign wr_idx      = wr_addr[4:2];
    assign start_req   = wr_en && (wr_idx == ADDR_CTRL[4:2]) && wr_strb[0] && wr_data[0];
    assign done_clr    = wr_en && (wr_idx == ADDR_STATUS[4:2]) && wr_strb[0]
                         && wr_data[STATUS_DONE_BIT];
    assign npu_arg0    = arg0_q;
    assign npu_arg1    = arg1_q;
    assign S_AXI_RRESP = RESP_OKAY;

    // Byte-masked updates of the four read/write registers.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            ctrl_q    <= '0;
            arg0_q    <= '0;
            arg1_q    <= '0;
            scratch_q <= '0;
        end else if (wr_en) begin
            case (wr_idx)
                ADDR_CTRL[4:2]:    ctrl_q    <= apply_strb(ctrl_q, wr_data, wr_strb);
                ADDR_ARG0[4:2]:    arg0_q    <= apply_strb(arg0_q, wr_data, wr_strb);
                ADDR_ARG1[4:2]:    arg1_q    <= apply_strb(arg1_q, wr_data, wr_strb);
                ADDR_SCRATCH[4:2]: scratch_q <= apply_strb(scratch_q, wr_data, wr_strb);
                default: ;
            endcase
        end
    end

    // Start pulse, busy/done tracking and the saturating busy-cycle counter.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            npu_start <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            cycles_q  <= '0;
        end else begin
            npu_start <= start_req;
            if (npu_start) begin
                busy_q <= 1'b1;
            end else if (npu_done) begin
                busy_q <= 1'b0;
            end
            if (npu_done) begin
                done_q <= 1'b1;
            end else if (done_clr) begin
                done_q <= 1'b0;
            end
            if (npu_start) begin
                cycles_q <= '0;
            end else if (busy_q && (cycles_q != 32'hFFFF_FFFF)) begin
                cycles_q <= cycles_q + 32'd1;
            end
        end
    end

    // Read data selection; unmapped offsets return zero.
    always_comb begin
        rd_word = '0;
        case (S_AXI_ARADDR[4:2])
            ADDR_CTRL[4:2]:    rd_word = ctrl_q;
            ADDR_ARG0[4:2]:    rd_word = arg0_q;
            ADDR_ARG1[4:2]:    rd_word = arg1_q;
            ADDR_SCRATCH[4:2]: rd_word = scratch_q;
            ADDR_STATUS[4:2]: begin
                rd_word[STATUS_BUSY_BIT] = busy_q;
                rd_word[STATUS_DONE_BIT] = done_q;
            end
            ADDR_CYCLES[4:2]:  rd_word = cycles_q;
            default:           rd_word = '0;
        endcase
    end

    // Read channel: ARREADY pulse, then registered data held until RREADY.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            S_AXI_ARREADY <= 1'b0;
            S_AXI_RVALID  <= 1'b0;
            S_AXI_RDATA   <= '0;
        end else begin
            S_AXI_ARREADY <= !S_AXI_ARREADY && S_AXI_ARVALID && !S_AXI_RVALID;
            if (S_AXI_ARREADY && S_AXI_ARVALID) begin
                S_AXI_RVALID <= 1'b1;
                S_AXI_RDATA  <= rd_word;
            end else if (S_AXI_RVALID && S_AXI_RREADY) begin
                S_AXI_RVALID <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_npu_ctrl_axil_regs.sv
// Directed bench for npu_ctrl_axil_regs: register readback, byte strobes,
// W-before-AW ordering, start/done/cycle counting, sticky-done clear,
// back-pressure on B and R, and asynchronous reset mid-transaction.
module tb_npu_ctrl_axil_regs;

    localparam logic [4:0] A_CTRL    = 5'h00;
    localparam logic [4:0] A_ARG0    = 5'h04;
    localparam logic [4:0] A_ARG1    = 5'h08;
    localparam logic [4:0] A_SCRATCH = 5'h0C;
    localparam logic [4:0] A_STATUS  = 5'h10;
    localparam logic [4:0] A_CYCLES  = 5'h14;
    localparam logic [4:0] A_UNMAP   = 5'h18;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [4:0]  awaddr = '0;
    logic [2:0]  awprot = '0;
    logic        awvalid = 1'b0;
    logic        awready;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = '0;
    logic        wvalid = 1'b0;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready = 1'b1;
    logic [4:0]  araddr = '0;
    logic [2:0]  arprot = '0;
    logic        arvalid = 1'b0;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready = 1'b1;
    logic        npu_start;
    logic [31:0] npu_arg0;
    logic [31:0] npu_arg1;
    logic        npu_done = 1'b0;

    int errors = 0;
    int checks = 0;
    int start_pulses = 0;
    int b_samples = 0;

    npu_ctrl_axil_regs dut (
        .S_AXI_ACLK    (clk),
        .S_AXI_ARESETN (rst_n),
        .S_AXI_AWADDR  (awaddr),
        .S_AXI_AWPROT  (awprot),
        .S_AXI_AWVALID (awvalid),
        .S_AXI_AWREADY (awready),
        .S_AXI_WDATA   (wdata),
        .S_AXI_WSTRB   (wstrb),
        .S_AXI_WVALID  (wvalid),
        .S_AXI_WREADY  (wready),
        .S_AXI_BRESP   (bresp),
        .S_AXI_BVALID  (bvalid),
        .S_AXI_BREADY  (bready),
        .S_AXI_ARADDR  (araddr),
        .S_AXI_ARPROT  (arprot),
        .S_AXI_ARVALID (arvalid),
        .S_AXI_ARREADY (arready),
        .S_AXI_RDATA   (rdata),
        .S_AXI_RRESP   (rresp),
        .S_AXI_RVALID  (rvalid),
        .S_AXI_RREADY  (rready),
        .npu_start     (npu_start),
        .npu_arg0      (npu_arg0),
        .npu_arg1      (npu_arg1),
        .npu_done      (npu_done)
    );

    always #5 clk = ~clk;

    // Count start pulses and B-valid cycles, sampled mid-cycle.
    always @(negedge clk) begin
        if (npu_start) start_pulses++;
        if (bvalid) b_samples++;
    end

    // Hard stop if the sequence ever stalls outside its own bounded waits.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    // Present AW and W (W leads AW by aw_delay cycles); returns at the
    // falling edge right after both handshakes completed.
    task automatic drive_aw_w(input logic [4:0] a, input logic [31:0] d,
                              input logic [3:0] s, input int aw_delay);
        int   cnt;
        logic aw_pend;
        logic w_pend;
        logic aw_fire;
        logic w_fire;
        awaddr  = a;
        wdata   = d;
        wstrb   = s;
        wvalid  = 1'b1;
        awvalid = (aw_delay == 0);
        aw_pend = 1'b1;
        w_pend  = 1'b1;
        cnt     = 0;
        while ((aw_pend || w_pend) && cnt < 50) begin
            aw_fire = awvalid && awready;
            w_fire  = wvalid && wready;
            @(negedge clk);
            cnt++;
            if (aw_fire) begin awvalid = 1'b0; aw_pend = 1'b0; end
            if (w_fire)  begin wvalid  = 1'b0; w_pend  = 1'b0; end
            if (aw_pend && !awvalid && cnt >= aw_delay) awvalid = 1'b1;
        end
        awvalid = 1'b0;
        wvalid  = 1'b0;
        check("aw_w_handshake", 32'({aw_pend, w_pend}), 32'd0);
    endtask

    task automatic wait_b(output logic [1:0] resp);
        int cnt;
        cnt    = 0;
        bready = 1'b1;
        while (!bvalid && cnt < 20) begin @(negedge clk); cnt++; end
        check("b_valid_seen", 32'(bvalid), 32'd1);
        resp = bresp;
        @(negedge clk);
    endtask

    task automatic axi_write(input logic [4:0] a, input logic [31:0] d,
                             input logic [3:0] s, input int aw_delay);
        logic [1:0] resp;
        drive_aw_w(a, d, s, aw_delay);
        wait_b(resp);
        check("bresp_okay", 32'(resp), 32'd0);
    endtask

    // Read one register; with hold>0, RREADY stays low for hold cycles
    // while a second AR is offered and RDATA must not move.
    task automatic axi_read(input logic [4:0] a, input int hold, output logic [31:0] data);
        int   cnt;
        int   stable;
        int   ar_seen;
        logic fire;
        araddr  = a;
        arvalid = 1'b1;
        rready  = (hold == 0);
        cnt     = 0;
        while (arvalid && cnt < 50) begin
            fire = arready;
            @(negedge clk);
            cnt++;
            if (fire) arvalid = 1'b0;
        end
        check("ar_handshake", 32'(arvalid), 32'd0);
        arvalid = 1'b0;
        cnt = 0;
        while (!rvalid && cnt < 20) begin @(negedge clk); cnt++; end
        check("r_valid_seen", 32'(rvalid), 32'd1);
        check("rresp_okay", 32'(rresp), 32'd0);
        data = rdata;
        if (hold > 0) begin
            stable  = 0;
            ar_seen = 0;
            araddr  = A_ARG0;
            arvalid = 1'b1;
            repeat (hold) begin
                @(negedge clk);
                if (rvalid && rdata === data) stable++;
                if (arready) ar_seen++;
            end
            arvalid = 1'b0;
            check("r_hold_stable", 32'(stable), 32'(hold));
            check("ar_blocked_during_r", 32'(ar_seen), 32'd0);
            rready = 1'b1;
        end
        @(negedge clk);
        check("r_released", 32'(rvalid), 32'd0);
    endtask

    logic [31:0] rd;
    logic [1:0]  resp;
    int          cnt;
    int          b_before;
    int          aw_seen;
    int          b_held;

    // Directed sequence.
    initial begin
        $display("[TB] start");
        repeat (2) @(negedge clk);
        check("reset_handshake_outputs",
              32'({awready, wready, bvalid, arready, rvalid, npu_start}), 32'd0);
        check("reset_rdata", rdata, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic readback; only the CTRL write should start the core.
        axi_write(A_CTRL,    32'd1, 4'hF, 0);
        axi_write(A_ARG0,    32'd2, 4'hF, 0);
        axi_write(A_ARG1,    32'd3, 4'hF, 0);
        axi_write(A_SCRATCH, 32'd4, 4'hF, 0);
        axi_read(A_CTRL, 0, rd);    check("rd_ctrl", rd, 32'd1);
        axi_read(A_ARG0, 0, rd);    check("rd_arg0", rd, 32'd2);
        axi_read(A_ARG1, 0, rd);    check("rd_arg1", rd, 32'd3);
        axi_read(A_SCRATCH, 0, rd); check("rd_scratch", rd, 32'd4);
        check("start_pulse_count", 32'(start_pulses), 32'd1);
        check("npu_arg0_live", npu_arg0, 32'd2);
        check("npu_arg1_live", npu_arg1, 32'd3);
        axi_read(A_STATUS, 0, rd);  check("status_busy", rd, 32'h1);

        // Byte strobes with W arriving three cycles before AW.
        axi_write(A_ARG0, 32'hFFFF_FFFF, 4'hF, 0);
        b_before = b_samples;
        axi_write(A_ARG0, 32'hA5A5_A5A5, 4'b0011, 3);
        check("single_bvalid", 32'(b_samples - b_before), 32'd1);
        axi_read(A_ARG0, 0, rd);    check("rd_arg0_strb", rd, 32'hFFFF_A5A5);
        check("npu_arg0_strb", npu_arg0, 32'hFFFF_A5A5);

        // Unmapped offset: write dropped, read zero.
        axi_write(A_UNMAP, 32'hDEAD_BEEF, 4'hF, 0);
        axi_read(A_UNMAP, 0, rd);   check("rd_unmapped", rd, 32'd0);
        axi_read(A_SCRATCH, 0, rd); check("scratch_untouched", rd, 32'd4);

        // Start, ten busy cycles, done pulse.
        axi_write(A_CTRL, 32'd1, 4'hF, 0);
        cnt = 0;
        while (!npu_start && cnt < 10) begin @(negedge clk); cnt++; end
        check("start_seen", 32'(npu_start), 32'd1);
        repeat (10) @(negedge clk);
        npu_done = 1'b1;
        @(negedge clk);
        npu_done = 1'b0;
        check("start_pulse_count2", 32'(start_pulses), 32'd2);
        axi_read(A_STATUS, 0, rd);  check("status_done", rd, 32'h2);
        axi_read(A_CYCLES, 0, rd);  check("cycles_10", rd, 32'd10);
        axi_write(A_STATUS, 32'h2, 4'hF, 0);
        axi_read(A_STATUS, 0, rd);  check("status_w1c", rd, 32'h0);

        // done pulse in the same cycle as the W1C update: set wins.
        drive_aw_w(A_STATUS, 32'h2, 4'hF, 0);
        npu_done = 1'b1;
        wait_b(resp);
        npu_done = 1'b0;
        axi_read(A_STATUS, 0, rd);  check("status_set_wins", rd, 32'h2);

        // B back-pressure with a second AW waiting.
        bready = 1'b0;
        drive_aw_w(A_SCRATCH, 32'h1234_5678, 4'hF, 0);
        cnt = 0;
        while (!bvalid && cnt < 20) begin @(negedge clk); cnt++; end
        check("b_pending", 32'(bvalid), 32'd1);
        awaddr  = A_ARG1;
        awvalid = 1'b1;
        aw_seen = 0;
        b_held  = 0;
        repeat (5) begin
            @(negedge clk);
            if (awready) aw_seen++;
            if (bvalid) b_held++;
        end
        check("aw_blocked_during_b", 32'(aw_seen), 32'd0);
        check("b_held", 32'(b_held), 32'd5);
        bready = 1'b1;
        @(negedge clk);
        check("b_released", 32'(bvalid), 32'd0);
        cnt = 0;
        while (!awready && cnt < 10) begin @(negedge clk); cnt++; end
        check("aw_accepted_after_b", 32'(awready), 32'd1);
        drive_aw_w(A_ARG1, 32'hCAFE_0001, 4'hF, 0);
        wait_b(resp);
        axi_read(A_ARG1, 0, rd);    check("rd_arg1_after_stall", rd, 32'hCAFE_0001);
        axi_read(A_SCRATCH, 5, rd); check("rd_scratch_r_stall", rd, 32'h1234_5678);

        // Reset with R, B and the start pulse all active.
        araddr  = A_STATUS;
        arvalid = 1'b1;
        rready  = 1'b0;
        cnt = 0;
        while (!rvalid && cnt < 20) begin @(negedge clk); cnt++; end
        arvalid = 1'b0;
        bready  = 1'b0;
        drive_aw_w(A_CTRL, 32'd1, 4'hF, 0);
        @(negedge clk);
        check("pre_reset_active", 32'({rvalid, bvalid, npu_start}), 32'h7);
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_outputs", 32'({rvalid, bvalid, npu_start, awready, wready, arready}), 32'd0);
        repeat (2) @(negedge clk);
        rst_n  = 1'b1;
        bready = 1'b1;
        rready = 1'b1;
        @(negedge clk);
        axi_read(A_CTRL, 0, rd);    check("post_reset_ctrl", rd, 32'd0);
        axi_read(A_ARG0, 0, rd);    check("post_reset_arg0", rd, 32'd0);
        axi_read(A_ARG1, 0, rd);    check("post_reset_arg1", rd, 32'd0);
        axi_read(A_SCRATCH, 0, rd); check("post_reset_scratch", rd, 32'd0);
        axi_read(A_STATUS, 0, rd);  check("post_reset_status", rd, 32'd0);
        axi_read(A_CYCLES, 0, rd);  check("post_reset_cycles", rd, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
